// File: rtl/popcount_sched.sv
// ---------------------------------------------------------------------------
// popcount_sched
//
// Two-requester front end for a single shared 8-bit bit-count resource.
// A word accepted from either requester is fed through the one num_bit
// instance a byte per cycle, least-significant byte first, and the per-byte
// counts are summed into a result of ones (or zeros) over the whole word.
// The result is returned together with the index of the requester it
// belongs to, so the counter need not be replicated per consumer.
//
// Parameters:
//   NBYTES  bytes per word (W = 8*NBYTES), minimum 1
//   CW      result width, wide enough to hold W
//
// Ports:
//   clk         single clock
//   rst_n       synchronous active-low reset
//   reqN_valid  requester N offers a word
//   reqN_ready  requester N's word is accepted at this edge
//   reqN_data   requester N's word
//   reqN_ones   1 = count ones, 0 = count zeros
//   out_valid   result available (held until out_ready)
//   out_ready   consumer takes the result
//   out_count   total count over all W bits
//   out_id      requester index the result belongs to
//   busy        high whenever the sequencer is not idle
// ---------------------------------------------------------------------------

// Shared 8-bit bit counter: counts bits equal to the requested polarity.
module num_bit (
    input  logic [7:0] signal,
    input  logic       ones,
    output logic [7:0] count
);

    // Counting bits that match 'ones' covers both the ones and zeros cases.
    always_comb begin
        count = '0;
        for (int i = 0; i < 8; i++) begin
            count = count + 8'(signal[i] == ones);
        end
    end

endmodule

module popcount_sched #(
    parameter int NBYTES = 4,
    parameter int CW     = $clog2(8*NBYTES+1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [8*NBYTES-1:0] req0_data,
    input  logic              req0_ones,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [8*NBYTES-1:0] req1_data,
    input  logic              req1_ones,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CW-1:0]     out_count,
    output logic              out_id,
    output logic              busy
);

    localparam int W  = 8 * NBYTES;
    localparam int BW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_e;

    state_e          state_q, state_d;
    logic [W-1:0]    word_q, word_d;
    logic            ones_q, ones_d;
    logic            id_q, id_d;
    logic [CW-1:0]   acc_q, acc_d;
    logic [BW-1:0]   byte_idx_q, byte_idx_d;
    logic            last_q, last_d;

    logic            grant_vld;
    logic            grant_id;
    logic [7:0]      nb_signal;
    logic [7:0]      nb_count;

    num_bit u_num_bit (
        .signal (nb_signal),
        .ones   (ones_q),
        .count  (nb_count)
    );

    // Byte currently being counted, least-significant byte first.
    assign nb_signal = word_q[8*byte_idx_q +: 8];

    // Arbitration is only open in IDLE and while out of reset, so readies
    // are low during reset and at most one requester is ever granted.
    // On contention the requester not served last time wins.
    always_comb begin
        grant_vld = 1'b0;
        grant_id  = 1'b0;
        if (state_q == IDLE && rst_n) begin
            if (req0_valid && req1_valid) begin
                grant_vld = 1'b1;
                grant_id  = ~last_q;
            end else if (req0_valid) begin
                grant_vld = 1'b1;
                grant_id  = 1'b0;
            end else if (req1_valid) begin
                grant_vld = 1'b1;
                grant_id  = 1'b1;
            end
        end
    end

    assign req0_ready = grant_vld && !grant_id;
    assign req1_ready = grant_vld &&  grant_id;

    // State register. 'last' starts at 1 so requester 0 wins the first
    // contention after reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            word_q     <= '0;
            ones_q     <= 1'b0;
            id_q       <= 1'b0;
            acc_q      <= '0;
            byte_idx_q <= '0;
            last_q     <= 1'b1;
        end else begin
            state_q    <= state_d;
            word_q     <= word_d;
            ones_q     <= ones_d;
            id_q       <= id_d;
            acc_q      <= acc_d;
            byte_idx_q <= byte_idx_d;
            last_q     <= last_d;
        end
    end

    // Next-state and datapath. The accepted word is latched so the
    // requester is free to change its data after the accept edge; the
    // accumulator can never exceed W, so CW bits never overflow.
    always_comb begin
        state_d    = state_q;
        word_d     = word_q;
        ones_d     = ones_q;
        id_d       = id_q;
        acc_d      = acc_q;
        byte_idx_d = byte_idx_q;
        last_d     = last_q;
        case (state_q)
            IDLE: begin
                if (grant_vld) begin
                    state_d    = RUN;
                    word_d     = grant_id ? req1_data : req0_data;
                    ones_d     = grant_id ? req1_ones : req0_ones;
                    id_d       = grant_id;
                    last_d     = grant_id;
                    acc_d      = '0;
                    byte_idx_d = '0;
                end
            end
            RUN: begin
                acc_d = acc_q + CW'(nb_count);
                if (byte_idx_q == BW'(NBYTES-1)) begin
                    state_d = DONE;
                end else begin
                    byte_idx_d = byte_idx_q + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs are decoded from the registered state, so the result and its
    // ID stay stable for as long as the consumer stalls.
    always_comb begin
        out_valid = (state_q == DONE);
        out_count = (state_q == DONE) ? acc_q : '0;
        out_id    = (state_q == DONE) ? id_q : 1'b0;
        busy      = (state_q != IDLE);
    end

endmodule
